// File: rtl/debug_host_link_if.sv
// Byte/word side channels of the debug host link: program source,
// tx/rx byte handshakes and the assembled dump word.
interface debug_host_link_if #(
    parameter int WIDTH_WORD           = 8,
    parameter int LONGITUD_INSTRUCCION = 32,
    parameter int ADDR_LENGTH          = 10
);
    logic [ADDR_LENGTH-1:0]          o_prog_addr;
    logic [LONGITUD_INSTRUCCION-1:0] i_prog_data;
    logic                            o_tx_start;
    logic [WIDTH_WORD-1:0]           o_data_tx;
    logic                            i_tx_done;
    logic                            i_rx_done;
    logic [WIDTH_WORD-1:0]           i_data_rx;
    logic [LONGITUD_INSTRUCCION-1:0] o_word;
    logic                            o_word_valid;

    modport master (
        output o_prog_addr, o_tx_start, o_data_tx, o_word, o_word_valid,
        input  i_prog_data, i_tx_done, i_rx_done, i_data_rx
    );

    modport slave (
        input  o_prog_addr, o_tx_start, o_data_tx, o_word, o_word_valid,
        output i_prog_data, i_tx_done, i_rx_done, i_data_rx
    );
endinterface

// File: rtl/debug_host_link.sv
// Host-side debug UART initiator: streams a program image, issues
// the run command, then assembles the dump into words.
module debug_host_link #(
    parameter int                    WIDTH_WORD           = 8,
    parameter int                    LONGITUD_INSTRUCCION = 32,
    parameter int                    ADDR_LENGTH          = 10,
    parameter logic [5:0]            HALT_OPCODE          = 6'd0,
    parameter logic [WIDTH_WORD-1:0] CMD_LOAD             = 8'h01,
    parameter logic [WIDTH_WORD-1:0] CMD_EXEC             = 8'h02,
    parameter int                    N_DUMP_WORDS         = 4,
    parameter int                    TIMEOUT_CYCLES       = 2000000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_start,
    output logic o_busy,
    output logic o_done,
    output logic o_error,
    debug_host_link_if.master bus
);
    localparam int L     = LONGITUD_INSTRUCCION;
    localparam int W     = WIDTH_WORD;
    localparam int BYTES = L / W;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int WCW   = $clog2(N_DUMP_WORDS + 1);
    localparam int TCW   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(N_DUMP_WORDS - 1);
    localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, SEND_LOAD, FETCH, SEND_BYTE, WAIT_TX,
        SEND_EXEC, RECV, DONE, ERROR
    } state_t;

    // What the byte currently in flight was, so WAIT_TX knows where to go.
    typedef enum logic [1:0] {
        K_LOAD, K_DATA, K_EXEC
    } kind_t;

    state_t       state;
    kind_t        kind;
    logic [L-1:0] shift;
    logic [L-W-1:0] rx_shift;
    logic [L-1:0] rx_next;
    logic [BCW-1:0] byte_cnt;
    logic [WCW-1:0] word_cnt;
    logic [TCW-1:0] tmo;
    logic         fetch_wait;
    logic         halt;

    // Received byte enters at the LSB side, earlier bytes move up.
    always_comb begin
        rx_next = {rx_shift, bus.i_data_rx};
    end

    // Protocol sequencer with registered outputs.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state            <= IDLE;
            kind             <= K_LOAD;
            shift            <= '0;
            rx_shift         <= '0;
            byte_cnt         <= '0;
            word_cnt         <= '0;
            tmo              <= '0;
            fetch_wait       <= 1'b0;
            halt             <= 1'b0;
            bus.o_prog_addr  <= '0;
            bus.o_tx_start   <= 1'b0;
            bus.o_data_tx    <= '0;
            bus.o_word       <= '0;
            bus.o_word_valid <= 1'b0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_error          <= 1'b0;
        end else begin
            bus.o_tx_start   <= 1'b0;
            bus.o_word_valid <= 1'b0;
            // Timeout only accumulates while waiting; any other cycle clears it.
            tmo              <= '0;
            unique case (state)
                IDLE, DONE, ERROR: begin
                    if (i_start) begin
                        state           <= SEND_LOAD;
                        bus.o_prog_addr <= '0;
                        byte_cnt        <= '0;
                        word_cnt        <= '0;
                        fetch_wait      <= 1'b0;
                        o_busy          <= 1'b1;
                        o_done          <= 1'b0;
                        o_error         <= 1'b0;
                    end
                end
                SEND_LOAD: begin
                    bus.o_tx_start <= 1'b1;
                    bus.o_data_tx  <= CMD_LOAD;
                    kind           <= K_LOAD;
                    state          <= WAIT_TX;
                end
                FETCH: begin
                    if (!fetch_wait) begin
                        fetch_wait <= 1'b1;
                    end else begin
                        fetch_wait <= 1'b0;
                        shift      <= bus.i_prog_data;
                        halt       <= (bus.i_prog_data[L-1 -: 6] == HALT_OPCODE);
                        byte_cnt   <= '0;
                        state      <= SEND_BYTE;
                    end
                end
                SEND_BYTE: begin
                    bus.o_tx_start <= 1'b1;
                    bus.o_data_tx  <= shift[L-1 -: W];
                    shift          <= shift << W;
                    kind           <= K_DATA;
                    state          <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (bus.i_tx_done) begin
                        unique case (kind)
                            K_LOAD: begin
                                state <= FETCH;
                            end
                            K_EXEC: begin
                                byte_cnt <= '0;
                                word_cnt <= '0;
                                state    <= RECV;
                            end
                            default: begin
                                if (byte_cnt != LAST_BYTE) begin
                                    byte_cnt <= byte_cnt + 1'b1;
                                    state    <= SEND_BYTE;
                                end else if (halt) begin
                                    state <= SEND_EXEC;
                                end else if (&bus.o_prog_addr) begin
                                    o_error <= 1'b1;
                                    o_busy  <= 1'b0;
                                    state   <= ERROR;
                                end else begin
                                    bus.o_prog_addr <= bus.o_prog_addr + 1'b1;
                                    state           <= FETCH;
                                end
                            end
                        endcase
                    end else if (tmo == TMO_LAST) begin
                        o_error <= 1'b1;
                        o_busy  <= 1'b0;
                        state   <= ERROR;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                SEND_EXEC: begin
                    bus.o_tx_start <= 1'b1;
                    bus.o_data_tx  <= CMD_EXEC;
                    kind           <= K_EXEC;
                    state          <= WAIT_TX;
                end
                RECV: begin
                    if (bus.i_rx_done) begin
                        rx_shift <= rx_next[L-W-1:0];
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt         <= '0;
                            bus.o_word       <= rx_next;
                            bus.o_word_valid <= 1'b1;
                            if (word_cnt == LAST_WORD) begin
                                o_done <= 1'b1;
                                o_busy <= 1'b0;
                                state  <= DONE;
                            end else begin
                                word_cnt <= word_cnt + 1'b1;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end else if (tmo == TMO_LAST) begin
                        o_error <= 1'b1;
                        o_busy  <= 1'b0;
                        state   <= ERROR;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
